// File: rtl/tx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tx_frame_sequencer : pops bytes from a FWFT FIFO and sends start/data/stop
// Revision 1.0 - initial release
// ============================================================================
module tx_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              EN,
  input  logic [DIV_W-1:0]  BAUDDIV,
  input  logic              FIFO_EMPTY,
  input  logic [DATA_W-1:0] FIFO_DATA,
  output logic              FIFO_POP,
  output logic              TX,
  output logic              BUSY,
  output logic              TXDONE,
  output logic              TXEMPTY
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DIV_W-1:0]  div_q, div_nxt;
  logic [DIV_W-1:0]  cnt, cnt_nxt;
  logic              bit_end;
  logic              go;

  assign bit_end = (cnt == '0);
  assign go      = EN && !FIFO_EMPTY;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state <= S_IDLE;
      shreg <= '0;
      idx   <= '0;
      div_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      idx   <= idx_nxt;
      div_q <= div_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter reloads from the latched divisor, so a BAUDDIV change only lands at FETCH.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    div_nxt   = div_q;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        shreg_nxt = FIFO_DATA;
        div_nxt   = BAUDDIV;
        cnt_nxt   = BAUDDIV;
        idx_nxt   = '0;
        state_nxt = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_nxt   = div_q;
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt   = div_q;
          shreg_nxt = shreg >> 1;
          if (idx == LAST_IDX) state_nxt = S_STOP;
          else                 idx_nxt   = idx + 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt   = div_q;
          state_nxt = go ? S_FETCH : S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    TX       = 1'b1;
    FIFO_POP = (state == S_FETCH);
    BUSY     = (state != S_IDLE);
    TXDONE   = (state == S_STOP) && bit_end;
    TXEMPTY  = (state == S_IDLE) && FIFO_EMPTY;
    case (state)
      S_START: TX = 1'b0;
      S_DATA:  TX = shreg[0];
      default: TX = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tx_frame_sequencer : frame-timing model check plus directed scenarios
// Revision 1.0 - initial release
// ============================================================================
module tb_tx_frame_sequencer;

  logic       clk = 1'b0;
  logic       nrst, en, fifo_empty, fifo_pop, tx, busy, txdone, txempty;
  logic [7:0] bauddiv, fifo_data;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tx_frame_sequencer #(.DATA_W(8), .DIV_W(8)) dut (
    .CLK(clk), .NRST(nrst), .EN(en), .BAUDDIV(bauddiv),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_POP(fifo_pop),
    .TX(tx), .BUSY(busy), .TXDONE(txdone), .TXEMPTY(txempty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: time offset t within a frame of 1 + 10*(div+1) cycles.
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  int         m_div  = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    if (!nrst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (en && !fifo_empty) begin
        m_busy <= 1'b1;
        m_t    <= 0;
      end
    end else begin
      if (m_t == 0) begin
        m_byte <= fifo_data;
        m_div  <= int'(bauddiv);
        rd_ptr <= rd_ptr + 1;
      end
      if (m_t != 0 && m_t == 10 * (m_div + 1)) begin
        if (en && !fifo_empty) m_t <= 0;
        else                   m_busy <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int   s, bitn;
      logic etx, edone;
      etx   = 1'b1;
      edone = 1'b0;
      if (m_busy && m_t > 0) begin
        s    = m_t - 1;
        bitn = s / (m_div + 1);
        if (bitn == 0)      etx = 1'b0;
        else if (bitn <= 8) etx = m_byte[bitn-1];
        edone = (bitn == 9) && ((s % (m_div + 1)) == m_div);
      end
      check("tx",      {31'd0, tx},       {31'd0, etx});
      check("busy",    {31'd0, busy},     {31'd0, m_busy});
      check("pop",     {31'd0, fifo_pop}, {31'd0, (m_busy && m_t == 0)});
      check("txdone",  {31'd0, txdone},   {31'd0, edone});
      check("txempty", {31'd0, txempty},  {31'd0, (!m_busy && fifo_empty)});
    end
  end

  // Cumulative history used by the literal expectations.
  int   cyc = 0;
  int   busy_total = 0;
  int   pop_total = 0;
  int   done_n = 0;
  int   done_at [0:63];
  logic txh [0:4095];

  always @(negedge clk) begin
    cyc           <= cyc + 1;
    txh[cyc[11:0]] <= tx;
    busy_total    <= busy_total + int'(busy);
    pop_total     <= pop_total + int'(fifo_pop);
    if (txdone) begin
      done_at[done_n[5:0]] <= cyc;
      done_n               <= done_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Finds the first TX fall at or after c0 and samples nbits at the given stride.
  task automatic frame_bits(input int c0, input int per, input int nbits,
                            output logic [31:0] bits, output int ff);
    ff   = -1;
    bits = '0;
    for (int c = c0 + 1; c < cyc; c++) begin
      if (ff < 0 && txh[(c-1) & 4095] && !txh[c & 4095]) ff = c;
    end
    if (ff >= 0)
      for (int k = 0; k < nbits; k++) bits[k] = txh[(ff + k*per) & 4095];
  endtask

  int          c0, b0, p0, d0, ff;
  logic [31:0] bits;
  logic [31:0] pat;

  initial begin
    nrst    = 1'b0;
    en      = 1'b1;
    bauddiv = 8'd3;
    push(8'hA5);
    tick(1);
    chk_en = 1'b1;
    tick(1);
    check("rst_pop_count", pop_total, 0);
    check("rst_tx", {31'd0, tx}, 1);

    // Single byte 0xA5 at 4 cycles per bit
    c0 = cyc; b0 = busy_total; p0 = pop_total; d0 = done_n;
    nrst = 1'b1;
    tick(60);
    frame_bits(c0, 4, 10, bits, ff);
    pat = {22'd0, 1'b1, 8'hA5, 1'b0};
    check("a5_bits", bits, pat);
    check("a5_busy_cycles", busy_total - b0, 41);
    check("a5_pops", pop_total - p0, 1);
    check("a5_done_count", done_n - d0, 1);
    check("a5_done_offset", done_at[(done_n-1) & 63] - ff, 39);
    check("a5_txempty", {31'd0, txempty}, 1);

    // Back-to-back 0x00, 0xFF at 1 cycle per bit
    bauddiv = 8'd0;
    push(8'h00);
    push(8'hFF);
    c0 = cyc; b0 = busy_total; p0 = pop_total; d0 = done_n;
    tick(40);
    frame_bits(c0, 1, 21, bits, ff);
    pat = {11'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    check("b2b_bits", bits, pat);
    check("b2b_busy_cycles", busy_total - b0, 22);
    check("b2b_pops", pop_total - p0, 2);
    check("b2b_done_count", done_n - d0, 2);
    check("b2b_done_gap", done_at[(done_n-1) & 63] - done_at[(done_n-2) & 63], 11);

    // Divisor and enable change during data bit 2 of 0x3C
    bauddiv = 8'd1;
    push(8'h3C);
    push(8'h99);
    c0 = cyc; b0 = busy_total; p0 = pop_total;
    tick(8);
    bauddiv = 8'd7;
    en      = 1'b0;
    tick(40);
    frame_bits(c0, 2, 10, bits, ff);
    pat = {22'd0, 1'b1, 8'h3C, 1'b0};
    check("mid_bits", bits, pat);
    check("mid_busy_cycles", busy_total - b0, 21);
    check("mid_pops", pop_total - p0, 1);
    check("mid_idle_busy", {31'd0, busy}, 0);
    check("mid_txempty", {31'd0, txempty}, 0);

    // Reset during data bit 4 of 0x99, then a fresh 0x5A frame
    bauddiv = 8'd1;
    en      = 1'b1;
    tick(12);
    nrst = 1'b0;
    push(8'h5A);
    tick(1);
    check("rst_mid_tx", {31'd0, tx}, 1);
    check("rst_mid_busy", {31'd0, busy}, 0);
    c0 = cyc; b0 = busy_total; p0 = pop_total;
    nrst = 1'b1;
    tick(30);
    frame_bits(c0, 2, 10, bits, ff);
    pat = {22'd0, 1'b1, 8'h5A, 1'b0};
    check("rst_new_bits", bits, pat);
    check("rst_new_busy_cycles", busy_total - b0, 21);
    check("rst_new_pops", pop_total - p0, 1);

    // Maximum divisor, 256 cycles per bit
    bauddiv = 8'd255;
    push(8'h01);
    c0 = cyc; b0 = busy_total; p0 = pop_total;
    tick(2600);
    frame_bits(c0, 256, 10, bits, ff);
    pat = {22'd0, 1'b1, 8'h01, 1'b0};
    check("max_bits", bits, pat);
    check("max_busy_cycles", busy_total - b0, 2561);
    check("max_pops", pop_total - p0, 1);
    check("max_done_offset", done_at[(done_n-1) & 63] - ff, 2559);
    check("max_txempty", {31'd0, txempty}, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
